spectro_frame_rx: RTL and testbench
===================================

Name: spectro_frame_rx

Overview:
- Deserializer at the far end of the spectrogram serial link.
- The link carries 16 slots per frame: slot 0 is RTC, slots 1..15 are filter channels. Each slot is a WORD_W-bit word sent MSB first. A slot-load strobe (sl) marks the first bit of each slot. A single-cycle frame_end strobe follows the last slot.
- The block rebuilds each word, tags it with its slot index, and presents it on a valid/ready port.
- It checks frame structure and flags framing and overrun errors for the downstream buffer or host interface.

Parameters:
- WORD_W, 12, bits per slot word (equals the slot length in clocks).
- NUM_SLOTS, 16, slots per frame (RTC plus 15 channels).
- SLOT_W, 4, width of the slot index; must satisfy 2^SLOT_W >= NUM_SLOTS.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sdata  in  1  serial data bit, sampled every clock.
- sl  in  1  slot-start strobe; high on the clock carrying a slot's MSB.
- frame_end  in  1  single-cycle end-of-frame strobe.
- word_data  out  WORD_W  received word.
- word_slot  out  SLOT_W  slot index of word_data (0 = RTC).
- word_valid  out  1  word_data/word_slot valid.
- word_ready  in  1  consumer accepts the word when valid && ready.
- frame_done  out  1  one-cycle pulse on a correctly terminated frame.
- frame_err  out  1  sticky framing error.
- overrun_err  out  1  sticky overrun error.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset (reset_n low, asynchronous) forces the state to IDLE and clears the shift register, bit counter and slot counter. All outputs go to 0, including word_data and word_slot.
- Bit order:
  - The bit sampled on the cycle sl=1 is bit WORD_W-1 of the new slot word.
  - The next WORD_W-1 cycles supply bits WORD_W-2..0.
  - A slot therefore occupies exactly WORD_W clocks.
  - The next slot's sl is required on the clock immediately after a slot's bit 0.
- FSM states: IDLE, RECV, WAIT_END.
- IDLE:
  - sl=1: shift in sdata, bit_cnt=1, slot=0, go to RECV.
  - sdata and frame_end are ignored.
- RECV, each clock, when bit_cnt != 0: shift in sdata and increment bit_cnt.
  - sl=1 here is a framing error: set frame_err, then treat this cycle as the start of slot 0 of a new frame (bit_cnt=1, slot=0).
  - frame_end=1 here is a framing error: set frame_err and go to IDLE.
- RECV, when bit_cnt reaches WORD_W (word complete): load the holding register with {shifted word, slot}.
  - If slot = NUM_SLOTS-1, go to WAIT_END.
  - Otherwise bit_cnt=0 and slot increments; the next cycle must have sl=1.
  - Next cycle sl=1 at bit_cnt=0: sample the MSB, bit_cnt=1.
  - Next cycle sl=0 at bit_cnt=0: set frame_err and go to IDLE.
- WAIT_END:
  - frame_end=1: pulse frame_done for one cycle, go to IDLE.
  - sl=1 without frame_end: set frame_err, start a new frame at slot 0.
  - Both sl=1 and frame_end=1 in the same cycle: frame_done pulses and the new frame starts at slot 0.
  - WAIT_END has no timeout; it holds until frame_end or sl.
- Word latency: word_valid rises on the clock after bit 0 is sampled.
- Output handshake:
  - word_valid stays high until a cycle with word_ready=1; word_data and word_slot stay stable meanwhile.
  - Completion while valid && !ready: the new word overwrites the held one, word_valid stays high, overrun_err is set.
  - Completion while valid && ready: the old word is consumed, the new word loads, no overrun.
- Sticky errors: err_clr clears both. If err_clr and a new error occur in the same cycle, the error is set.
- Counters never exceed their bound. slot wraps to 0 only through a new sl.

Optional Feature:
- Macro: SPECTRO_RX_FRAME_CNT_EN.
- Defined: adds output frame_cnt [7:0].
  - Reset value 0.
  - Increments, wrapping 255->0, on each frame_done pulse.
  - err_clr does not affect it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package spectro_pkg holds:
  - WORD_W and NUM_SLOTS defaults.
  - SLOT_W.
  - The slot-index constant SLOT_RTC=0.
  - The rx state enum {IDLE, RECV, WAIT_END}.
- One sub-module, spectro_rx_hold: the one-entry valid/ready holding register with overrun detection.
- Shift register and FSM stay in the top module.

Test Plan:
- Nominal frame:
  - Stimulus: 16 back-to-back slots with words 12'hA50+slot, then frame_end, word_ready held 1.
  - Required: 16 word_valid beats with slots 0..15 and matching data, then one frame_done pulse; frame_err=0, overrun_err=0.
- Overrun:
  - Stimulus: word_ready=0 through slots 0 and 1.
  - Required: after slot 1, word_data=12'hA51, word_slot=1, overrun_err=1.
  - Then err_clr: overrun_err returns to 0.
- Missing sl:
  - Stimulus: sl held low at the start of slot 5.
  - Required: frame_err=1, state IDLE, no word with slot 5.
  - A following full frame is received correctly from slot 0.
- Early sl:
  - Stimulus: sl at bit 6 of slot 3.
  - Required: frame_err=1, no slot-3 word; the next word emitted is slot 0, built from the bits starting at the early sl.
- Missing frame_end:
  - Stimulus: after slot 15, sl with no frame_end.
  - Required: frame_err=1, no frame_done, new frame starts at slot 0.
- Reset mid-slot:
  - Stimulus: reset_n pulsed low during slot 7 with word_valid=1.
  - Required: immediately word_valid=0, errors=0, IDLE.
  - With SPECTRO_RX_FRAME_CNT_EN: frame_cnt=0, and after two good frames frame_cnt=2.

Source files
------------

// File: rtl/spectro_pkg.sv
// -----------------------------------------------------------------------------
// spectro_pkg
// Shared definitions for the spectrogram serial-link receiver.
//   SPECTRO_WORD_W    : default bits per slot word (also slot length in clocks)
//   SPECTRO_NUM_SLOTS : default slots per frame (RTC + 15 filter channels)
//   SPECTRO_SLOT_W    : width of the slot index
//   SLOT_RTC          : slot index of the RTC word
//   rx_state_e        : receiver FSM states
// -----------------------------------------------------------------------------
package spectro_pkg;

  localparam int SPECTRO_WORD_W    = 12;
  localparam int SPECTRO_NUM_SLOTS = 16;
  localparam int SPECTRO_SLOT_W    = 4;

  localparam logic [SPECTRO_SLOT_W-1:0] SLOT_RTC = '0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_END
  } rx_state_e;

endpackage : spectro_pkg

// File: rtl/spectro_rx_hold.sv
// -----------------------------------------------------------------------------
// spectro_rx_hold
// One-entry valid/ready holding register for received slot words.
// A load always wins: if the held word has not been taken, it is overwritten
// and overrun_o pulses for that cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : a completed word is presented this cycle
//   data_i/slot_i: completed word and its slot index
//   ready_i      : consumer accepts the held word when valid_o && ready_i
//   valid_o      : held word valid
//   data_o/slot_o: held word and slot index (0 while reset)
//   overrun_o    : single-cycle pulse, load while an untaken word is held
// -----------------------------------------------------------------------------
module spectro_rx_hold #(
  parameter int WORD_W = 12,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              overrun_o
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q,  data_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    slot_d    = slot_q;
    overrun_o = 1'b0;
    if (load_i) begin
      valid_d   = 1'b1;
      data_d    = data_i;
      slot_d    = slot_i;
      // Only a word still waiting (not taken this cycle) is lost.
      overrun_o = valid_q & ~ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      slot_q  <= slot_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign slot_o  = slot_q;

endmodule : spectro_rx_hold

// File: rtl/spectro_frame_rx.sv
// -----------------------------------------------------------------------------
// spectro_frame_rx
// Deserializer for the spectrogram serial link. Rebuilds MSB-first slot words,
// tags them with their slot index, presents them on a valid/ready port and
// checks frame structure (sl at every slot start, frame_end after last slot).
// Optional build macro: SPECTRO_RX_FRAME_CNT_EN adds frame_cnt[7:0], a
// wrapping count of correctly terminated frames (unaffected by err_clr).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   sdata, sl, frame_end  : serial bit, slot-start strobe, end-of-frame strobe
//   word_data/word_slot   : received word and slot index (0 = RTC)
//   word_valid/word_ready : output handshake
//   frame_done            : one-cycle pulse on a correctly terminated frame
//   frame_err/overrun_err : sticky errors, cleared by err_clr
//   frame_cnt             : (macro only) terminated-frame counter
// -----------------------------------------------------------------------------
module spectro_frame_rx
  import spectro_pkg::*;
#(
  parameter int WORD_W    = SPECTRO_WORD_W,
  parameter int NUM_SLOTS = SPECTRO_NUM_SLOTS,
  parameter int SLOT_W    = SPECTRO_SLOT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdata,
  input  logic              sl,
  input  logic              frame_end,
  output logic [WORD_W-1:0] word_data,
  output logic [SLOT_W-1:0] word_slot,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overrun_err,
  input  logic              err_clr
`ifdef SPECTRO_RX_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  localparam int BCNT_W = $clog2(WORD_W + 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  rx_state_e           state_q, state_d;
  // Holds the bits received so far; the final bit is taken straight from
  // sdata, so only WORD_W-1 bits ever need storing.
  logic [WORD_W-2:0]   shift_q, shift_d;
  // Bits received in the current slot; 0 means "waiting for the next sl".
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, overrun_err_q;

  logic                ferr_set;
  logic                word_load;
  logic [WORD_W-1:0]   word_full;
  logic                overrun_pulse;

  assign word_full = {shift_q, sdata};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    ferr_set     = 1'b0;
    word_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sl) begin
          shift_d   = {{(WORD_W-2){1'b0}}, sdata};
          bit_cnt_d = BCNT_ONE;
          slot_d    = SLOT_RTC;
          state_d   = RECV;
        end
      end

      RECV: begin
        if (frame_end) begin
          ferr_set  = 1'b1;
          bit_cnt_d = '0;
          slot_d    = SLOT_RTC;
          state_d   = IDLE;
        end else if (sl) begin
          // sl mid-slot abandons the frame and restarts at the RTC slot;
          // sl at bit_cnt 0 is the expected start of the next slot.
          if (bit_cnt_q != '0) begin
            ferr_set = 1'b1;
            slot_d   = SLOT_RTC;
          end
          shift_d   = {{(WORD_W-2){1'b0}}, sdata};
          bit_cnt_d = BCNT_ONE;
        end else if (bit_cnt_q == '0) begin
          // Slot boundary without its sl.
          ferr_set = 1'b1;
          slot_d   = SLOT_RTC;
          state_d  = IDLE;
        end else begin
          shift_d = word_full[WORD_W-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            // This cycle carries bit 0: the word is complete.
            word_load = 1'b1;
            bit_cnt_d = '0;
            if (slot_q == LAST_SLOT) begin
              state_d = WAIT_END;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_ONE;
          end
        end
      end

      WAIT_END: begin
        if (frame_end) begin
          frame_done_d = 1'b1;
        end
        if (sl) begin
          // A new frame may start in the same cycle as frame_end.
          if (!frame_end) begin
            ferr_set = 1'b1;
          end
          shift_d   = {{(WORD_W-2){1'b0}}, sdata};
          bit_cnt_d = BCNT_ONE;
          slot_d    = SLOT_RTC;
          state_d   = RECV;
        end else if (frame_end) begin
          slot_d  = SLOT_RTC;
          state_d = IDLE;
        end
      end

      default: begin
        bit_cnt_d = '0;
        slot_d    = SLOT_RTC;
        state_d   = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      slot_q        <= SLOT_RTC;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_q        <= slot_d;
      frame_done_q  <= frame_done_d;
      // A new error in the clearing cycle must survive the clear.
      frame_err_q   <= ferr_set | (frame_err_q & ~err_clr);
      overrun_err_q <= overrun_pulse | (overrun_err_q & ~err_clr);
    end
  end

`ifdef SPECTRO_RX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Counts alongside the frame_done pulse so both become visible together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_done_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  spectro_rx_hold #(
    .WORD_W (WORD_W),
    .SLOT_W (SLOT_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (word_load),
    .data_i    (word_full),
    .slot_i    (slot_q),
    .ready_i   (word_ready),
    .valid_o   (word_valid),
    .data_o    (word_data),
    .slot_o    (word_slot),
    .overrun_o (overrun_pulse)
  );

  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule : spectro_frame_rx

// File: tb/tb_spectro_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spectro_frame_rx
// Drives whole frames bit by bit and compares the accepted words, frame_done
// pulses and sticky errors against expectations derived from the frame
// structure (which words each scenario must deliver, and in what order).
// -----------------------------------------------------------------------------
module tb_spectro_frame_rx;

  localparam int WW = 12;
  localparam int NS = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sdata = 1'b0;
  logic          sl = 1'b0;
  logic          frame_end = 1'b0;
  logic          word_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic [WW-1:0] word_data;
  logic [SW-1:0] word_slot;
  logic          word_valid;
  logic          frame_done;
  logic          frame_err;
  logic          overrun_err;
`ifdef SPECTRO_RX_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  // Accepted words as {slot, data}; written only by the monitor.
  logic [SW+WW-1:0] got_q[$];
  // Words each scenario requires; written only by the test tasks.
  logic [SW+WW-1:0] exp_q[$];

  always #5 clk = ~clk;

  spectro_frame_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sdata       (sdata),
    .sl          (sl),
    .frame_end   (frame_end),
    .word_data   (word_data),
    .word_slot   (word_slot),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .err_clr     (err_clr)
`ifdef SPECTRO_RX_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  // A word is accepted on the rising edge following a negedge where
  // valid && ready, since inputs only change just after rising edges.
  always @(negedge clk) begin
    if (word_valid && word_ready) got_q.push_back({word_slot, word_data});
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // One link clock: apply inputs, let the DUT sample them, return just after.
  task automatic tick(input logic sd, input logic s, input logic fe);
    sdata = sd;
    sl = s;
    frame_end = fe;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [WW-1:0] w, input int nbits,
                           input logic with_sl, input logic fe_first);
    logic [WW-1:0] wv;
    wv = w;
    for (int i = 0; i < nbits; i++)
      tick(wv[WW-1-i], with_sl && (i == 0), fe_first && (i == 0));
  endtask

  // Full 16-slot frame (no frame_end); random words unless rnd=0.
  task automatic send_frame(input logic [WW-1:0] base, input bit rnd,
                            input logic fe_first);
    logic [WW-1:0] w;
    for (int s = 0; s < NS; s++) begin
      w = rnd ? WW'($urandom) : base + WW'(s);
      exp_q.push_back({SW'(s), w});
      send_bits(w, WW, 1'b1, fe_first && (s == 0));
    end
  endtask

  // Idle gap: random sdata, occasional stray frame_end (ignored in IDLE).
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    sl = 1'b1;
    #1;
    vectors++;
    if ({word_valid, frame_done, frame_err, overrun_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got v/d/fe/ov=%b required 0000",
               {word_valid, frame_done, frame_err, overrun_err});
    end
    vectors++;
    if ({word_slot, word_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_word: got slot=%0d data=%h required 0/000", word_slot, word_data);
    end
`ifdef SPECTRO_RX_FRAME_CNT_EN
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
`endif
    sl = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int base, d0;
    exp_q.delete();
    base = got_q.size();
    d0 = done_cnt;
    word_ready = 1'b1;
    send_frame(12'hA50, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    idle(2);
    vectors++;
    if (got_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL nominal_count: got %0d words required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL nominal_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL nominal_done: got %0d pulse-cycles required 1", done_cnt - d0);
    end
    vectors++;
    if ({frame_err, overrun_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL nominal_errs: got fe/ov=%b required 00", {frame_err, overrun_err});
    end
  endtask

  task automatic test_overrun();
    int base;
    base = got_q.size();
    word_ready = 1'b0;
    send_bits(12'hA50, WW, 1'b1, 1'b0);
    send_bits(12'hA51, WW, 1'b1, 1'b0);
    vectors++;
    if ({word_valid, word_slot, word_data, overrun_err} !== {1'b1, 4'd1, 12'hA51, 1'b1}) begin
      miscompares++;
      $display("FAIL overrun_hold: got v=%b slot=%0d data=%h ov=%b required 1/1/a51/1",
               word_valid, word_slot, word_data, overrun_err);
    end
    // Clear in the same cycle as the missing-sl error: overrun clears,
    // frame error must still be set.
    clear_errs();
    vectors++;
    if ({overrun_err, frame_err} !== 2'b01) begin
      miscompares++;
      $display("FAIL overrun_clear: got ov/fe=%b required 01", {overrun_err, frame_err});
    end
    word_ready = 1'b1;
    idle(2);
    vectors++;
    if (got_q.size() - base !== 1 || got_q[base] !== {4'd1, 12'hA51}) begin
      miscompares++;
      $display("FAIL overrun_drain: got %0d words (first %h) required 1 word 1a51",
               got_q.size() - base, (got_q.size() > base) ? got_q[base] : 16'h0);
    end
    clear_errs();
    vectors++;
    if ({frame_err, word_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL overrun_after: got fe/v=%b required 00", {frame_err, word_valid});
    end
  endtask

  task automatic test_missing_sl();
    int base, d0;
    logic [WW-1:0] w;
    exp_q.delete();
    base = got_q.size();
    d0 = done_cnt;
    for (int s = 0; s < 5; s++) begin
      w = WW'($urandom);
      exp_q.push_back({SW'(s), w});
      send_bits(w, WW, 1'b1, 1'b0);
    end
    send_bits(WW'($urandom), WW, 1'b0, 1'b0);
    idle(1);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL missing_sl_err: got frame_err=%b required 1", frame_err);
    end
    clear_errs();
    send_frame('0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    idle(2);
    vectors++;
    if (got_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL missing_sl_count: got %0d words required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL missing_sl_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL missing_sl_recover: got done=%0d fe=%b required 1/0", done_cnt - d0, frame_err);
    end
  endtask

  task automatic test_early_sl();
    int base, d0;
    logic [WW-1:0] w;
    exp_q.delete();
    base = got_q.size();
    d0 = done_cnt;
    for (int s = 0; s < 3; s++) begin
      w = WW'($urandom);
      exp_q.push_back({SW'(s), w});
      send_bits(w, WW, 1'b1, 1'b0);
    end
    send_bits(WW'($urandom), 6, 1'b1, 1'b0);  // slot 3 cut short
    send_frame('0, 1'b1, 1'b0);               // its sl lands on bit 6
    tick(1'b0, 1'b0, 1'b1);
    idle(2);
    vectors++;
    if (got_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL early_sl_count: got %0d words required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL early_sl_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
      end
    end
    vectors++;
    if (frame_err !== 1'b1 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL early_sl_status: got fe=%b done=%0d required 1/1", frame_err, done_cnt - d0);
    end
    clear_errs();
  endtask

  task automatic test_missing_frame_end();
    int base, d0;
    exp_q.delete();
    base = got_q.size();
    d0 = done_cnt;
    send_frame('0, 1'b1, 1'b0);
    send_frame('0, 1'b1, 1'b0);   // sl straight after slot 15, no frame_end
    vectors++;
    if (frame_err !== 1'b1 || done_cnt - d0 !== 0) begin
      miscompares++;
      $display("FAIL no_fe_status: got fe=%b done=%0d required 1/0", frame_err, done_cnt - d0);
    end
    tick(1'b0, 1'b0, 1'b1);
    idle(2);
    vectors++;
    if (got_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL no_fe_count: got %0d words required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL no_fe_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL no_fe_done: got %0d required 1", done_cnt - d0);
    end
    clear_errs();
  endtask

  task automatic test_back_to_back();
    int base, d0;
    bit combined;
    exp_q.delete();
    base = got_q.size();
    d0 = done_cnt;
    combined = 1'b0;
    for (int f = 0; f < 5; f++) begin
      send_frame('0, 1'b1, combined);
      combined = (f < 4) && ($urandom_range(0, 1) == 1);
      if (!combined) begin
        tick(1'($urandom), 1'b0, 1'b1);
        idle($urandom_range(0, 3));
      end
    end
    idle(2);
    vectors++;
    if (got_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 5 || {frame_err, overrun_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_status: got done=%0d fe/ov=%b required 5/00",
               done_cnt - d0, {frame_err, overrun_err});
    end
  endtask

  task automatic test_reset_mid();
    int base, d0;
    word_ready = 1'b0;
    for (int s = 0; s < 7; s++) send_bits(WW'($urandom), WW, 1'b1, 1'b0);
    send_bits(WW'($urandom), 5, 1'b1, 1'b0);  // part of slot 7
    vectors++;
    if ({word_valid, overrun_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got v/ov=%b required 11", {word_valid, overrun_err});
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({word_valid, frame_err, overrun_err, frame_done} !== 4'b0000 ||
        {word_slot, word_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got v/fe/ov/d=%b slot=%0d data=%h required 0000/0/000",
               {word_valid, frame_err, overrun_err, frame_done}, word_slot, word_data);
    end
`ifdef SPECTRO_RX_FRAME_CNT_EN
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid_cnt: got %0d required 0", frame_cnt);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    base = got_q.size();
    d0 = done_cnt;
    word_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_frame('0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
    end
    idle(2);
    vectors++;
    if (got_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL reset_mid_count: got %0d words required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_mid_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 2) begin
      miscompares++;
      $display("FAIL reset_mid_done: got %0d required 2", done_cnt - d0);
    end
`ifdef SPECTRO_RX_FRAME_CNT_EN
    vectors++;
    if (frame_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL reset_mid_frame_cnt: got %0d required 2", frame_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_missing_sl();
    test_early_sl();
    test_missing_frame_end();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_spectro_frame_rx
